coeff_loader: RTL and testbench

Writer-side companion to the registered 11-entry coefficient select mux. Accepts a stream of 32-bit polynomial coefficients over a valid/ready handshake after a load command. Stores them in order into 11 registered outputs, coeff0..coeff10, which drive the mux inputs directly. Signals completion with a one-cycle done pulse and a level "coefficients valid" flag.

---
 rtl/coeff_loader.sv | 97 +++++++++
 tb/tb_coeff_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_loader.sv
// Writer side of the 11-entry coefficient mux: loads a stream of words over a
// valid/ready handshake into registered coefficient outputs coeff0..coeff10.
module coeff_loader #(
    parameter int WIDTH     = 32,
    parameter int NUM_COEFF = 11
) (
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic             load_start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             load_busy,
    output logic             load_done,
    output logic             coeffs_valid,
    output logic [3:0]       load_count,
    output logic [WIDTH-1:0] coeff0,
    output logic [WIDTH-1:0] coeff1,
    output logic [WIDTH-1:0] coeff2,
    output logic [WIDTH-1:0] coeff3,
    output logic [WIDTH-1:0] coeff4,
    output logic [WIDTH-1:0] coeff5,
    output logic [WIDTH-1:0] coeff6,
    output logic [WIDTH-1:0] coeff7,
    output logic [WIDTH-1:0] coeff8,
    output logic [WIDTH-1:0] coeff9,
    output logic [WIDTH-1:0] coeff10
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_INDEX = 4'(NUM_COEFF - 1);
    localparam logic [3:0] COUNT_MAX  = 4'(NUM_COEFF);

    state_t           state;
    logic [WIDTH-1:0] coeff_q [NUM_COEFF];

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state        <= IDLE;
            load_count   <= '0;
            coeffs_valid <= 1'b0;
            for (int i = 0; i < NUM_COEFF; i++) begin
                coeff_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state        <= LOAD;
                        load_count   <= '0;
                        coeffs_valid <= 1'b0;
                    end
                end
                LOAD: begin
                    // The index guard keeps a corrupted count from ever writing past entry 10.
                    if (data_valid && (load_count < COUNT_MAX)) begin
                        coeff_q[load_count] <= data_in;
                        load_count          <= load_count + 4'd1;
                        if (load_count == LAST_INDEX) begin
                            state        <= DONE;
                            coeffs_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake and status flags are pure state decodes, so no input reaches an output combinationally.
    assign data_ready = (state == LOAD);
    assign load_busy  = (state == LOAD);
    assign load_done  = (state == DONE);

    assign coeff0  = coeff_q[0];
    assign coeff1  = coeff_q[1];
    assign coeff2  = coeff_q[2];
    assign coeff3  = coeff_q[3];
    assign coeff4  = coeff_q[4];
    assign coeff5  = coeff_q[5];
    assign coeff6  = coeff_q[6];
    assign coeff7  = coeff_q[7];
    assign coeff8  = coeff_q[8];
    assign coeff9  = coeff_q[9];
    assign coeff10 = coeff_q[10];

endmodule

// File: tb/tb_coeff_loader.sv
// Self-checking bench for coeff_loader: randomized loads compared against an
// array-based model of which words should land in which coefficient slot.
module tb_coeff_loader;

    logic        clk;
    logic        GlobalReset;
    logic        load_start;
    logic [31:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic        load_busy;
    logic        load_done;
    logic        coeffs_valid;
    logic [3:0]  load_count;
    logic [31:0] coeff0, coeff1, coeff2, coeff3, coeff4, coeff5;
    logic [31:0] coeff6, coeff7, coeff8, coeff9, coeff10;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_coeff [11];
    int          n_acc;
    bit          mid_start;

    coeff_loader #(.WIDTH(32), .NUM_COEFF(11)) dut (
        .clk          (clk),
        .GlobalReset  (GlobalReset),
        .load_start   (load_start),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .load_busy    (load_busy),
        .load_done    (load_done),
        .coeffs_valid (coeffs_valid),
        .load_count   (load_count),
        .coeff0       (coeff0),
        .coeff1       (coeff1),
        .coeff2       (coeff2),
        .coeff3       (coeff3),
        .coeff4       (coeff4),
        .coeff5       (coeff5),
        .coeff6       (coeff6),
        .coeff7       (coeff7),
        .coeff8       (coeff8),
        .coeff9       (coeff9),
        .coeff10      (coeff10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dut_coeff(input int k);
        case (k)
            0:  return coeff0;
            1:  return coeff1;
            2:  return coeff2;
            3:  return coeff3;
            4:  return coeff4;
            5:  return coeff5;
            6:  return coeff6;
            7:  return coeff7;
            8:  return coeff8;
            9:  return coeff9;
            default: return coeff10;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_coeffs(input string tag);
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (dut_coeff(k) !== exp_coeff[k]) begin
                failures++;
                $display("[TB] FAIL %s coeff%0d: got %h expected %h", tag, k, dut_coeff(k), exp_coeff[k]);
            end
        end
    endtask

    task automatic test_reset();
        GlobalReset = 1'b1;
        load_start  = 1'b0;
        data_valid  = 1'b0;
        data_in     = '0;
        tick();
        tick();
        for (int k = 0; k < 11; k++) exp_coeff[k] = '0;
        check_all_coeffs("reset");
        checks++;
        if ({data_ready, load_busy, load_done, coeffs_valid, load_count} !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 00000000",
                     {data_ready, load_busy, load_done, coeffs_valid, load_count});
        end
        GlobalReset = 1'b0;
        tick();
    endtask

    task automatic start_load(input bit junk);
        load_start = 1'b1;
        data_valid = junk;
        data_in    = 32'hDEADBEEF;
        tick();
        load_start = 1'b0;
        data_valid = 1'b0;
        n_acc      = 0;
        checks++;
        if ({load_busy, data_ready, coeffs_valid, load_count} !== 7'b1100000) begin
            failures++;
            $display("[TB] FAIL start_flags: got %b expected 1100000",
                     {load_busy, data_ready, coeffs_valid, load_count});
        end
        checks++;
        if (coeff0 !== exp_coeff[0]) begin
            failures++;
            $display("[TB] FAIL start_no_write: got %h expected %h", coeff0, exp_coeff[0]);
        end
    endtask

    // mode 0: back-to-back base+n; 1: alternating stalls base+n; 2: random words and stalls; 3: constant base
    task automatic feed_words(input int count, input int mode, input logic [31:0] base);
        int cycles = 0;
        int target = n_acc + count;
        while (n_acc < target && cycles < 400) begin
            logic        v;
            logic [31:0] w;
            case (mode)
                0:       begin v = 1'b1;                w = base + 32'(n_acc); end
                1:       begin v = cycles[0];           w = base + 32'(n_acc); end
                2:       begin v = 1'($urandom_range(0, 1)); w = $urandom; end
                default: begin v = 1'b1;                w = base; end
            endcase
            data_valid = v;
            data_in    = w;
            load_start = mid_start && (n_acc == 5);
            tick();
            load_start = 1'b0;
            cycles++;
            if (v) begin
                exp_coeff[n_acc] = w;
                n_acc++;
                checks++;
                if (dut_coeff(n_acc - 1) !== w) begin
                    failures++;
                    $display("[TB] FAIL write coeff%0d: got %h expected %h", n_acc - 1, dut_coeff(n_acc - 1), w);
                end
            end
            checks++;
            if (load_count !== 4'(n_acc)) begin
                failures++;
                $display("[TB] FAIL load_count: got %0d expected %0d", load_count, n_acc);
            end
            checks++;
            if ({load_done, data_ready, load_busy} !== {n_acc == 11, n_acc != 11, n_acc != 11}) begin
                failures++;
                $display("[TB] FAIL load_flags at %0d words: got %b", n_acc, {load_done, data_ready, load_busy});
            end
        end
        data_valid = 1'b0;
        if (n_acc < target) begin
            failures++;
            $display("[TB] FAIL feed_timeout: got %0d words expected %0d", n_acc, target);
        end
    endtask

    task automatic finish_load(input string tag);
        checks++;
        if ({load_done, coeffs_valid, data_ready, load_busy} !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL %s done_cycle: got %b expected 1100", tag,
                     {load_done, coeffs_valid, data_ready, load_busy});
        end
        tick();
        checks++;
        if ({load_done, coeffs_valid, data_ready, load_count} !== 7'b0101011) begin
            failures++;
            $display("[TB] FAIL %s after_done: got %b expected 0101011", tag,
                     {load_done, coeffs_valid, data_ready, load_count});
        end
        check_all_coeffs(tag);
    endtask

    task automatic test_back_to_back();
        start_load(1'b0);
        feed_words(11, 0, 32'h0000_0100);
        finish_load("b2b");
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (dut_coeff(k) !== 32'h100 + 32'(k)) begin
                failures++;
                $display("[TB] FAIL b2b_value coeff%0d: got %h expected %h", k, dut_coeff(k), 32'h100 + 32'(k));
            end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 11; k++) exp_coeff[k] = '0;
        GlobalReset = 1'b1;
        tick();
        GlobalReset = 1'b0;
        start_load(1'b0);
        feed_words(11, 1, 32'h0000_0100);
        finish_load("stall");
    endtask

    task automatic test_ignored_inputs();
        mid_start = 1'b1;
        start_load(1'b1);
        feed_words(11, 2, '0);
        mid_start = 1'b0;
        finish_load("mid_start");
        for (int i = 0; i < 3; i++) begin
            data_valid = 1'b1;
            data_in    = 32'hDEADBEEF;
            tick();
        end
        data_valid = 1'b0;
        checks++;
        if ({load_count, data_ready, coeffs_valid} !== 6'b101101) begin
            failures++;
            $display("[TB] FAIL idle_valid: got %b expected 101101", {load_count, data_ready, coeffs_valid});
        end
        check_all_coeffs("idle_valid");
    endtask

    task automatic test_abort_reset();
        start_load(1'b0);
        feed_words(6, 2, '0);
        GlobalReset = 1'b1;
        tick();
        GlobalReset = 1'b0;
        for (int k = 0; k < 11; k++) exp_coeff[k] = '0;
        check_all_coeffs("abort");
        checks++;
        if ({coeffs_valid, load_busy, data_ready, load_count} !== 7'b0) begin
            failures++;
            $display("[TB] FAIL abort_flags: got %b expected 0000000",
                     {coeffs_valid, load_busy, data_ready, load_count});
        end
        start_load(1'b0);
        feed_words(11, 2, '0);
        finish_load("after_abort");
    endtask

    task automatic test_partial_reload();
        start_load(1'b0);
        feed_words(3, 3, 32'hFFFF_FFFF);
        check_all_coeffs("partial");
        checks++;
        if ({coeffs_valid, load_busy} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL partial_flags: got %b expected 01", {coeffs_valid, load_busy});
        end
        feed_words(8, 2, '0);
        finish_load("partial_complete");
    endtask

    task automatic test_hold_valid();
        start_load(1'b0);
        for (int i = 0; i < 15; i++) begin
            logic [31:0] w;
            w          = $urandom;
            data_valid = 1'b1;
            data_in    = w;
            tick();
            if (i < 11) exp_coeff[i] = w;
            checks++;
            if (load_count !== 4'((i < 11) ? i + 1 : 11)) begin
                failures++;
                $display("[TB] FAIL hold_count cycle %0d: got %0d expected %0d", i, load_count, (i < 11) ? i + 1 : 11);
            end
            checks++;
            if (data_ready !== (i < 10)) begin
                failures++;
                $display("[TB] FAIL hold_ready cycle %0d: got %b expected %b", i, data_ready, i < 10);
            end
        end
        data_valid = 1'b0;
        check_all_coeffs("hold");
        checks++;
        if (coeffs_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_valid_flag: got %b expected 1", coeffs_valid);
        end
    endtask

    initial begin
        mid_start = 1'b0;
        test_reset();
        test_back_to_back();
        test_stall();
        test_ignored_inputs();
        for (int r = 0; r < 3; r++) begin
            start_load(1'b0);
            feed_words(11, 2, '0);
            finish_load("random");
        end
        test_abort_reset();
        test_partial_reload();
        test_hold_valid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
